// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the KCPU push/pull sequencer: postbyte layout, register slots, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package jtkcpu_pkg;

    // Postbyte bit positions double as register slot indices
    localparam int PB_CC    = 0;
    localparam int PB_A     = 1;
    localparam int PB_B     = 2;
    localparam int PB_DP    = 3;
    localparam int PB_X     = 4;
    localparam int PB_Y     = 5;
    localparam int PB_OTHER = 6;
    localparam int PB_PC    = 7;

    typedef enum logic [2:0] {
        SLOT_CC    = 3'd0,
        SLOT_A     = 3'd1,
        SLOT_B     = 3'd2,
        SLOT_DP    = 3'd3,
        SLOT_X     = 3'd4,
        SLOT_Y     = 3'd5,
        SLOT_OTHER = 3'd6,
        SLOT_PC    = 3'd7
    } slot_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PICK   = 3'd1,
        ST_ACC_HI = 3'd2,
        ST_ACC_LO = 3'd3,
        ST_ACC8   = 3'd4,
        ST_WB     = 3'd5,
        ST_FIN    = 3'd6
    } state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] other;
        logic [15:0] y;
        logic [15:0] x;
        logic [7:0]  dp;
        logic [7:0]  b;
        logic [7:0]  a;
        logic [7:0]  cc;
    } regs_t;

    // Slots X and above are the 16-bit registers
    function automatic logic slot_is16(input slot_e s);
        return (s >= SLOT_X);
    endfunction

    function automatic logic [15:0] reg_val(input regs_t r, input slot_e s);
        logic [15:0] v;
        v = 16'h0000;
        case (s)
            SLOT_CC:    v = {8'h00, r.cc};
            SLOT_A:     v = {8'h00, r.a};
            SLOT_B:     v = {8'h00, r.b};
            SLOT_DP:    v = {8'h00, r.dp};
            SLOT_X:     v = r.x;
            SLOT_Y:     v = r.y;
            SLOT_OTHER: v = r.other;
            SLOT_PC:    v = r.pc;
            default:    v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/jtkcpu_pshpul_pick.sv
// Priority encoder over the remaining postbyte bits: push takes the highest set bit, pull the lowest.
// Latency: combinational.
// Backpressure: none.
module jtkcpu_pshpul_pick
    import jtkcpu_pkg::*;
(
    input  logic [7:0] bits,
    input  logic       pull,
    output slot_e      slot,
    output logic       is16,
    output logic       none
);

    always_comb begin
        slot = SLOT_CC;
        if (pull) begin
            for (int i = 7; i >= 0; i--) begin
                if (bits[i]) slot = slot_e'(i[2:0]);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (bits[i]) slot = slot_e'(i[2:0]);
            end
        end
    end

    assign none = ~|bits;
    assign is16 = slot_is16(slot);

endmodule

// File: rtl/jtkcpu_pshpul.sv
// PSHS/PSHU/PULS/PULU sequencer: one byte per bus cycle, one PICK per register, WB strobe on pull.
// Latency: start->done = 2 + per register (1 + bytes + 1 if pull) cycles at zero wait; bus_ok stalls in place.
// Backpressure: holds bus_cs/addr/dout/we until bus_ok; optional JTKCPU_PSHPUL_WRAPCHK_EN adds wrap_err.
module jtkcpu_pshpul
    import jtkcpu_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pull,
    input  logic          use_u,
    input  logic [7:0]    postbyte,
    input  logic [AW-1:0] sp,
    input  logic [7:0]    cc,
    input  logic [7:0]    a,
    input  logic [7:0]    b,
    input  logic [7:0]    dp,
    input  logic [15:0]   x,
    input  logic [15:0]   y,
    input  logic [15:0]   other,
    input  logic [15:0]   pc,
    output logic [AW-1:0] bus_addr,
    output logic [7:0]    bus_dout,
    input  logic [7:0]    bus_din,
    output logic          bus_we,
    output logic          bus_cs,
    input  logic          bus_ok,
    output logic [15:0]   wr_data,
    output logic          up_cc,
    output logic          up_a,
    output logic          up_b,
    output logic          up_dp,
    output logic          up_x,
    output logic          up_y,
    output logic          up_other,
    output logic          up_pc,
    output logic          up_sp,
    output logic [AW-1:0] sp_nxt,
    output logic          busy,
    output logic          done,
    output logic          wrap_err
);

    state_e        st, st_nxt;
    logic [7:0]    pb;
    logic          dir_pull;
    logic [AW-1:0] ptr;
    regs_t         regs;
    slot_e         cur;
    logic [7:0]    hold_hi, hold_lo;

    slot_e         pk_slot;
    logic          pk_is16, pk_none;
    logic          acc, acc_ok;
    logic [15:0]   cur_val;
    logic [7:0]    up_vec;

    // The stack choice is resolved upstream: sp and other already arrive swapped
    logic unused_use_u;
    assign unused_use_u = use_u;

    jtkcpu_pshpul_pick u_pick (
        .bits (pb),
        .pull (dir_pull),
        .slot (pk_slot),
        .is16 (pk_is16),
        .none (pk_none)
    );

    assign acc    = (st == ST_ACC_HI) || (st == ST_ACC_LO) || (st == ST_ACC8);
    assign acc_ok = acc && bus_ok;

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:   if (start) st_nxt = ST_PICK;
            ST_PICK: begin
                if (pk_none)      st_nxt = ST_FIN;
                else if (pk_is16) st_nxt = dir_pull ? ST_ACC_HI : ST_ACC_LO;
                else              st_nxt = ST_ACC8;
            end
            ST_ACC_HI: if (bus_ok) st_nxt = dir_pull ? ST_ACC_LO : ST_PICK;
            ST_ACC_LO: if (bus_ok) st_nxt = dir_pull ? ST_WB : ST_ACC_HI;
            ST_ACC8:   if (bus_ok) st_nxt = dir_pull ? ST_WB : ST_PICK;
            ST_WB:     st_nxt = ST_PICK;
            ST_FIN:    st_nxt = ST_IDLE;
            default:   st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            pb       <= '0;
            dir_pull <= 1'b0;
            ptr      <= '0;
            regs     <= '0;
            cur      <= SLOT_CC;
            hold_hi  <= 8'h00;
            hold_lo  <= 8'h00;
        end else begin
            st <= st_nxt;
            if (st == ST_IDLE && start) begin
                pb       <= postbyte;
                dir_pull <= pull;
                ptr      <= sp;
                regs     <= '{pc: pc, other: other, y: y, x: x, dp: dp, b: b, a: a, cc: cc};
            end
            if (st == ST_PICK) begin
                cur <= pk_slot;
                if (!pk_none) pb[pk_slot] <= 1'b0;
            end
            if (acc_ok) begin
                // Push pre-decrements, pull post-increments
                ptr <= dir_pull ? ptr + AW'(1) : ptr - AW'(1);
                if (dir_pull) begin
                    if (st == ST_ACC_HI) begin
                        hold_hi <= bus_din;
                    end else begin
                        hold_lo <= bus_din;
                        if (st == ST_ACC8) hold_hi <= 8'h00;
                    end
                end
            end
        end
    end

`ifdef JTKCPU_PSHPUL_WRAPCHK_EN
    logic wrap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else if (st == ST_IDLE && start) begin
            wrap_q <= 1'b0;
        end else if (acc_ok && (dir_pull ? (&ptr) : (~|ptr))) begin
            wrap_q <= 1'b1;
        end
    end

    assign wrap_err = wrap_q;
`else
    assign wrap_err = 1'b0;
`endif

    assign cur_val  = reg_val(regs, cur);
    assign bus_cs   = acc;
    assign bus_we   = acc && !dir_pull;
    assign bus_addr = !acc ? '0 : (dir_pull ? ptr : ptr - AW'(1));
    // Low byte leaves first on push, so ACC_HI is the only state carrying [15:8]
    assign bus_dout = !bus_we ? 8'h00 : ((st == ST_ACC_HI) ? cur_val[15:8] : cur_val[7:0]);

    assign up_vec   = (st == ST_WB) ? (8'(1) << cur) : 8'h00;
    assign up_cc    = up_vec[PB_CC];
    assign up_a     = up_vec[PB_A];
    assign up_b     = up_vec[PB_B];
    assign up_dp    = up_vec[PB_DP];
    assign up_x     = up_vec[PB_X];
    assign up_y     = up_vec[PB_Y];
    assign up_other = up_vec[PB_OTHER];
    assign up_pc    = up_vec[PB_PC];
    assign wr_data  = (st == ST_WB) ? {hold_hi, hold_lo} : 16'h0000;

    assign busy     = (st != ST_IDLE);
    assign done     = (st == ST_FIN);
    assign up_sp    = done;
    assign sp_nxt   = done ? ptr : '0;

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Randomized bench for jtkcpu_pshpul against a byte-level stack model with a waitstate-injecting bus.
// Latency: checks start->done at zero wait.
// Backpressure: random and fixed bus_ok stalls, spurious bus_ok while idle.
module tb_jtkcpu_pshpul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, pull = 1'b0, use_u = 1'b0;
    logic [7:0]  postbyte = 8'h00, cc = 8'h00, a = 8'h00, b = 8'h00, dp = 8'h00;
    logic [15:0] sp = 16'h0000, x = 16'h0000, y = 16'h0000, other = 16'h0000, pc = 16'h0000;
    logic [7:0]  bus_din = 8'h00;
    logic        bus_ok = 1'b0;
    logic [15:0] bus_addr, wr_data, sp_nxt;
    logic [7:0]  bus_dout;
    logic        bus_we, bus_cs, up_cc, up_a, up_b, up_dp, up_x, up_y, up_other, up_pc;
    logic        up_sp, busy, done, wrap_err;

    jtkcpu_pshpul #(.AW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pull(pull), .use_u(use_u),
        .postbyte(postbyte), .sp(sp), .cc(cc), .a(a), .b(b), .dp(dp),
        .x(x), .y(y), .other(other), .pc(pc),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din), .bus_we(bus_we),
        .bus_cs(bus_cs), .bus_ok(bus_ok), .wr_data(wr_data),
        .up_cc(up_cc), .up_a(up_a), .up_b(up_b), .up_dp(up_dp), .up_x(up_x),
        .up_y(up_y), .up_other(up_other), .up_pc(up_pc), .up_sp(up_sp),
        .sp_nxt(sp_nxt), .busy(busy), .done(done), .wrap_err(wrap_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dat;
        logic        we;
        int          held;
        logic        stable;
    } acc_t;

    typedef struct {
        int          slot;
        logic [15:0] dat;
    } ev_t;

    acc_t        obs_acc[$], exp_acc[$];
    ev_t         obs_ev[$], exp_ev[$];
    logic [7:0]  mem [0:65535];
    logic [15:0] m_val [8];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    int          fin_n = 0, fin_cyc = 0, cs_cnt = 0;
    logic [15:0] fin_sp = 16'h0000;
    logic        fin_busy = 1'b0;
    int          wait_max = 0, fixed_wait = -1, hold_n = -1;
    bit          pend = 1'b0;
    acc_t        cur_a;
    int          waits = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bus_addr, bus_dout, bus_we, bus_cs, wr_data, up_cc, up_a, up_b, up_dp,
                 up_x, up_y, up_other, up_pc, up_sp, sp_nxt, busy, done, wrap_err};
    endfunction

    always @(posedge clk) cyc++;

    // Bus responder and output monitor, both sampled on the falling edge
    always @(negedge clk) begin
        logic [7:0] upv;
        ev_t        e;
        if (bus_cs) begin
            cs_cnt++;
            if (!pend) begin
                pend = 1'b1;
                cur_a.addr = bus_addr; cur_a.dat = bus_dout; cur_a.we = bus_we;
                cur_a.held = 0; cur_a.stable = 1'b1;
                if (hold_n >= 0 && obs_acc.size() >= hold_n) waits = 1 << 30;
                else if (fixed_wait >= 0)                    waits = fixed_wait;
                else                                          waits = $urandom_range(wait_max, 0);
            end else if (bus_addr !== cur_a.addr || bus_we !== cur_a.we || bus_dout !== cur_a.dat) begin
                cur_a.stable = 1'b0;
            end
            cur_a.held++;
            if (waits > 0) begin
                waits--;
                bus_ok = 1'b0;
                bus_din = 8'($urandom);
            end else begin
                bus_ok = 1'b1;
                if (bus_we) mem[bus_addr] = bus_dout;
                else        bus_din = mem[bus_addr];
                obs_acc.push_back(cur_a);
                pend = 1'b0;
            end
        end else begin
            pend = 1'b0;
            bus_ok = 1'($urandom_range(1, 0));
            bus_din = 8'($urandom);
        end
        upv = {up_pc, up_other, up_y, up_x, up_dp, up_b, up_a, up_cc};
        if (upv != 8'h00) begin
            chk("one_strobe", $countones(upv), 1);
            e.slot = 0;
            for (int i = 7; i >= 0; i--) if (upv[i]) e.slot = i;
            e.dat = wr_data;
            obs_ev.push_back(e);
        end
        if (up_sp) begin
            fin_n++;
            fin_sp = sp_nxt;
            fin_cyc = cyc;
            fin_busy = busy;
        end
    end

    // Stack model: pre-decrement push PC..CC, post-increment pull CC..PC
    task automatic model(input bit pl, input logic [7:0] pbv, input logic [15:0] spv,
                         output logic [15:0] sp_end, output bit wr, output int lat);
        logic [15:0] ptr, v;
        acc_t        t;
        ev_t         e;
        int          nb;
        ptr = spv; wr = 1'b0; lat = 2;
        exp_acc.delete(); exp_ev.delete();
        for (int k = 0; k < 8; k++) begin
            int s;
            s = pl ? k : 7 - k;
            if (pbv[s]) begin
                nb = (s >= 4) ? 2 : 1;
                lat += 1 + nb + (pl ? 1 : 0);
                v = 16'h0000;
                for (int j = 0; j < nb; j++) begin
                    t.held = 0; t.stable = 1'b1;
                    if (!pl) begin
                        if (ptr == 16'h0000) wr = 1'b1;
                        ptr = ptr - 16'd1;
                        t.addr = ptr; t.we = 1'b1;
                        t.dat = (j == 0) ? m_val[s][7:0] : m_val[s][15:8];
                    end else begin
                        if (ptr == 16'hFFFF) wr = 1'b1;
                        t.addr = ptr; t.we = 1'b0; t.dat = 8'h00;
                        v = {v[7:0], mem[ptr]};
                        ptr = ptr + 16'd1;
                    end
                    exp_acc.push_back(t);
                end
                if (pl) begin
                    e.slot = s; e.dat = v;
                    exp_ev.push_back(e);
                end
            end
        end
        sp_end = ptr;
    endtask

    task automatic run_op(input bit pl, input bit uu, input logic [7:0] pbv,
                          input logic [15:0] spv, input int wmax, input bit do_lat);
        logic [15:0] e_sp;
        bit          e_wr, exp_wrap;
        int          lat, t0, guard;
        wait_max = wmax;
        m_val[0] = {8'h00, cc}; m_val[1] = {8'h00, a}; m_val[2] = {8'h00, b}; m_val[3] = {8'h00, dp};
        m_val[4] = x; m_val[5] = y; m_val[6] = other; m_val[7] = pc;
        model(pl, pbv, spv, e_sp, e_wr, lat);
        obs_acc.delete(); obs_ev.delete(); fin_n = 0; cs_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; pull = pl; use_u = uu; postbyte = pbv; sp = spv; t0 = cyc;
        guard = 0;
        // Scramble every input while busy: the DUT must work from its latched copy
        do begin
            @(posedge clk); #1;
            start = 1'($urandom_range(1, 0)); pull = 1'($urandom_range(1, 0));
            use_u = 1'($urandom_range(1, 0)); postbyte = 8'($urandom); sp = 16'($urandom);
            cc = 8'($urandom); a = 8'($urandom); b = 8'($urandom); dp = 8'($urandom);
            x = 16'($urandom); y = 16'($urandom); other = 16'($urandom); pc = 16'($urandom);
            @(negedge clk); #1;
            guard++;
        end while (fin_n == 0 && guard < 3000);
        @(posedge clk); #1;
        start = 1'b0;
        if (fin_n == 0) begin
            chk("timeout", 0, 1);
            rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        end
        @(negedge clk); #1;
`ifdef JTKCPU_PSHPUL_WRAPCHK_EN
        exp_wrap = e_wr;
`else
        exp_wrap = 1'b0;
`endif
        chk("busy_after", busy, 0);
        chk("wrap_err", wrap_err, exp_wrap);
        chk("n_acc", obs_acc.size(), exp_acc.size());
        for (int i = 0; i < obs_acc.size() && i < exp_acc.size(); i++) begin
            chk("acc_addr", obs_acc[i].addr, exp_acc[i].addr);
            chk("acc_we", obs_acc[i].we, exp_acc[i].we);
            if (exp_acc[i].we) chk("acc_dat", obs_acc[i].dat, exp_acc[i].dat);
            chk("acc_stable", obs_acc[i].stable, 1);
        end
        chk("n_wb", obs_ev.size(), exp_ev.size());
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            chk("wb_slot", obs_ev[i].slot, exp_ev[i].slot);
            chk("wb_data", obs_ev[i].dat, exp_ev[i].dat);
        end
        chk("fin_count", fin_n, 1);
        chk("sp_nxt", fin_sp, e_sp);
        chk("busy_at_fin", fin_busy, 1);
        if (do_lat) chk("latency", fin_cyc - t0, lat);
    endtask

    function automatic logic [31:0] ev_dat(input int i);
        return (i < obs_ev.size()) ? {16'h0, obs_ev[i].dat} : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int guard;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", any_out(), 0);
        @(negedge clk); rst_n = 1'b1;

        // Push PC and A
        pc = 16'h1234; a = 8'h56;
        run_op(1'b0, 1'b0, 8'h82, 16'h1000, 0, 1'b1);
        chk("t1_0fff", mem[16'h0FFF], 8'h34);
        chk("t1_0ffe", mem[16'h0FFE], 8'h12);
        chk("t1_0ffd", mem[16'h0FFD], 8'h56);
        chk("t1_sp", fin_sp, 16'h0FFD);

        // Pull CC and X
        mem[16'h0FF0] = 8'hA5; mem[16'h0FF1] = 8'h12; mem[16'h0FF2] = 8'h34;
        run_op(1'b1, 1'b0, 8'h11, 16'h0FF0, 0, 1'b1);
        chk("t2_cc", ev_dat(0), 32'h0000_00A5);
        chk("t2_x", ev_dat(1), 32'h0000_1234);
        chk("t2_sp", fin_sp, 16'h0FF3);

        // Single write held by three wait states
        fixed_wait = 3; b = 8'h9C;
        run_op(1'b0, 1'b0, 8'h04, 16'h4000, 0, 1'b0);
        fixed_wait = -1;
        chk("t3_held", (obs_acc.size() > 0) ? obs_acc[0].held : -1, 4);
        chk("t3_mem", mem[16'h3FFF], 8'h9C);

        // Empty postbyte
        run_op(1'b0, 1'b0, 8'h00, 16'h1357, 0, 1'b1);
        chk("t4_cs", cs_cnt, 0);
        chk("t4_sp", fin_sp, 16'h1357);

        // U stack, wrap through zero
        a = 8'h77; cc = 8'h3E;
        run_op(1'b0, 1'b1, 8'h03, 16'h0001, 0, 1'b1);
        chk("t5_0000", mem[16'h0000], 8'h77);
        chk("t5_ffff", mem[16'hFFFF], 8'h3E);
        chk("t5_sp", fin_sp, 16'hFFFF);

        // Reset while the second byte of a pull X is pending
        obs_acc.delete(); obs_ev.delete(); hold_n = 1;
        @(posedge clk); #1;
        start = 1'b1; pull = 1'b1; postbyte = 8'h10; sp = 16'h2000;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        do begin
            @(negedge clk); #1;
            guard++;
        end while (!(bus_cs && obs_acc.size() == 1) && guard < 100);
        chk("t6_reached", guard < 100, 1);
        #2 rst_n = 1'b0;
        #1 chk("t6_outs_now", any_out(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("t6_no_up", obs_ev.size(), 0);
        hold_n = -1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("t6_idle", any_out(), 0);

        for (int k = 0; k < 40; k++) begin
            logic [7:0]  pbv;
            logic [15:0] spv;
            int          w;
            cc = 8'($urandom); a = 8'($urandom); b = 8'($urandom); dp = 8'($urandom);
            x = 16'($urandom); y = 16'($urandom); other = 16'($urandom); pc = 16'($urandom);
            pbv = 8'($urandom);
            if (k % 8 == 0) pbv = 8'h00;
            if (k % 5 == 0)      spv = 16'($urandom_range(2, 0));
            else if (k % 5 == 1) spv = 16'hFFFF - 16'($urandom_range(2, 0));
            else                 spv = 16'($urandom);
            w = (k % 3 == 0) ? 0 : int'($urandom_range(2, 0));
            run_op(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), pbv, spv, w, w == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
